mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter_pick.sv | 24 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: bus widths (common_types) and
// arbiter state/port encodings (mem_arb_types).

package common_types;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;
    typedef logic        mw_t;

endpackage : common_types

package mem_arb_types;

    typedef enum logic [1:0] {
        OPEN,
        LOCK_CPU,
        LOCK_LDR
    } arb_state_t;

    typedef enum logic {
        CPU,
        LDR
    } port_t;

    localparam int LOCK_MAX_DEFAULT = 4;

    function automatic port_t other_port(input port_t p);
        return (p == CPU) ? LDR : CPU;
    endfunction

endpackage : mem_arb_types

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters plus memory.

interface mem_arbiter_if;
    import common_types::*;

    logic  cpu_req;
    logic  cpu_we;
    logic  cpu_lock;
    addr_t cpu_addr;
    data_t cpu_wdata;
    logic  cpu_gnt;
    logic  cpu_rvalid;

    logic  ldr_req;
    logic  ldr_we;
    logic  ldr_lock;
    addr_t ldr_addr;
    data_t ldr_wdata;
    logic  ldr_gnt;
    logic  ldr_rvalid;

    data_t rdata;

    mw_t   mem_mw;
    addr_t mem_addr;
    data_t mem_wdata;
    data_t mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
        output cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, rdata,
        output mem_mw, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
        input  cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, rdata,
        input  mem_mw, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter_pick.sv
// Two-way combinational picker: fixed CPU priority, or round-robin against
// last_owner when rr is set. req[0]/gnt[0] = CPU, req[1]/gnt[1] = loader.

module arb_pick
    import mem_arb_types::*;
(
    input  logic [1:0] req,
    input  port_t      last_owner,
    input  logic       rr,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr && last_owner == CPU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule : arb_pick

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between CPU (port 0) and loader (port 1) with
// bounded bus locking. Define MEM_ARB_RR_EN for round-robin arbitration in OPEN.

module mem_arbiter
    import common_types::*;
    import mem_arb_types::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

`ifdef MEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

    arb_state_t state;
    port_t      last_owner;
    logic [3:0] lock_cnt;
    logic       cpu_rvalid_q;
    logic       ldr_rvalid_q;
    // Port owed the next contested cycle after a lock ended without a voluntary release.
    logic       fav_valid;
    port_t      fav_port;

    logic       cpu_gnt;
    logic       ldr_gnt;
    logic [1:0] pick_gnt;
    logic       pick_rr;
    port_t      pick_last;
    port_t      gnt_port;
    port_t      owner;
    logic       owner_req;
    logic       owner_lock;
    logic       granted_lock;

    always_comb begin
        pick_rr   = RR_EN || fav_valid;
        pick_last = fav_valid ? other_port(fav_port) : last_owner;
    end

    arb_pick u_pick (
        .req        ({bus.ldr_req, bus.cpu_req}),
        .last_owner (pick_last),
        .rr         (pick_rr),
        .gnt        (pick_gnt)
    );

    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        if (!rst) begin
            unique case (state)
                OPEN: begin
                    cpu_gnt = pick_gnt[0];
                    ldr_gnt = pick_gnt[1];
                end
                LOCK_CPU: cpu_gnt = bus.cpu_req;
                LOCK_LDR: ldr_gnt = bus.ldr_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt_port     = ldr_gnt ? LDR : CPU;
        granted_lock = (cpu_gnt && bus.cpu_lock) || (ldr_gnt && bus.ldr_lock);
        owner        = (state == LOCK_LDR) ? LDR : CPU;
        owner_req    = (owner == LDR) ? bus.ldr_req  : bus.cpu_req;
        owner_lock   = (owner == LDR) ? bus.ldr_lock : bus.cpu_lock;
    end

    // Idle cycles leave the CPU address/data on the bus with the write strobe low.
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_mw    = mw_t'(cpu_gnt && bus.cpu_we);
        if (ldr_gnt) begin
            bus.mem_addr  = bus.ldr_addr;
            bus.mem_wdata = bus.ldr_wdata;
            bus.mem_mw    = mw_t'(bus.ldr_we);
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.ldr_gnt    = ldr_gnt;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.ldr_rvalid = ldr_rvalid_q;
    assign bus.rdata      = (cpu_rvalid_q || ldr_rvalid_q) ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state        <= OPEN;
            last_owner   <= LDR;
            lock_cnt     <= 4'd0;
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            fav_valid    <= 1'b0;
            fav_port     <= CPU;
        end else begin
            cpu_rvalid_q <= cpu_gnt && !bus.cpu_we;
            ldr_rvalid_q <= ldr_gnt && !bus.ldr_we;
            if (cpu_gnt || ldr_gnt) begin
                last_owner <= gnt_port;
            end

            unique case (state)
                OPEN: begin
                    if (bus.cpu_req && bus.ldr_req) begin
                        fav_valid <= 1'b0;
                    end
                    if (granted_lock) begin
                        if (LOCK_MAX_C == 4'd1) begin
                            fav_valid <= 1'b1;
                            fav_port  <= other_port(gnt_port);
                        end else begin
                            state    <= (gnt_port == CPU) ? LOCK_CPU : LOCK_LDR;
                            lock_cnt <= 4'd1;
                        end
                    end
                end
                LOCK_CPU, LOCK_LDR: begin
                    if (!owner_req || (owner_lock && (lock_cnt + 4'd1 == LOCK_MAX_C))) begin
                        state     <= OPEN;
                        lock_cnt  <= 4'd0;
                        fav_valid <= 1'b1;
                        fav_port  <= other_port(owner);
                    end else if (!owner_lock) begin
                        state    <= OPEN;
                        lock_cnt <= 4'd0;
                    end else begin
                        lock_cnt <= lock_cnt + 4'd1;
                    end
                end
                default: state <= OPEN;
            endcase
        end
    end

endmodule : mem_arbiter
